// File: rtl/vga_pkg.sv
// Screen geometry, sprite sizes and point-FSM types shared by the VGA game blocks.
package vga_pkg;

  localparam int unsigned HOR_PIXELS  = 1024;
  localparam int unsigned VER_PIXELS  = 768;
  localparam int unsigned POINT_SIZE  = 8;
  localparam int unsigned PLAYER_SIZE = 16;
  localparam int unsigned POS_W       = 10;
  localparam int unsigned DIST_W      = 11;

  localparam logic [POS_W-1:0] POINT_FALLBACK_X = POS_W'(HOR_PIXELS / 2);
  localparam logic [POS_W-1:0] POINT_FALLBACK_Y = POS_W'(VER_PIXELS / 4);

  typedef enum logic [1:0] {SPAWN, ACTIVE, COLLECTED, COOLDOWN} point_state_t;

  // Absolute difference without wrap: compare first, then subtract the smaller operand.
  function automatic logic [DIST_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                 input logic [POS_W-1:0] b);
    if (a >= b) return DIST_W'(a) - DIST_W'(b);
    else        return DIST_W'(b) - DIST_W'(a);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/point_spawn_ctrl.sv
// Collectible point lifecycle: spawn at a random legal spot, wait for the player,
// count the collection, cool down, respawn.
module point_spawn_ctrl
  import vga_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned MAX_TRIES     = 8,
  parameter int unsigned RESPAWN_DELAY = 60,
  parameter int unsigned SPAWN_MARGIN  = 16,
  parameter int unsigned SCORE_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               game_en,
  input  logic [POS_W-1:0]   player_x,
  input  logic [POS_W-1:0]   player_y,
  output logic [POS_W-1:0]   point_x,
  output logic [POS_W-1:0]   point_y,
  output logic               point_active,
  output logic               collect_pulse,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned TRY_W   = 8;
  localparam int unsigned DELAY_W = 10;
  localparam logic [POS_W-1:0]  RESET_X   = POS_W'(HOR_PIXELS / 2);
  localparam logic [POS_W-1:0]  RESET_Y   = POS_W'(VER_PIXELS / 2);
  localparam logic [POS_W-1:0]  MIN_XY    = POS_W'(POINT_SIZE);
  localparam logic [POS_W-1:0]  MAX_X     = POS_W'(HOR_PIXELS - 1 - POINT_SIZE);
  localparam logic [POS_W-1:0]  MAX_Y     = POS_W'(VER_PIXELS - 1 - POINT_SIZE);
  localparam logic [DIST_W-1:0] HIT_DIST  = DIST_W'(POINT_SIZE + PLAYER_SIZE);
  localparam logic [DIST_W:0]   SPAWN_DIST = (DIST_W + 1)'(POINT_SIZE + PLAYER_SIZE + SPAWN_MARGIN);
  localparam logic [TRY_W-1:0]   LAST_TRY   = TRY_W'(MAX_TRIES - 1);
  localparam logic [DELAY_W-1:0] LAST_DELAY = DELAY_W'(RESPAWN_DELAY - 1);

  // Assertion is immediate, release waits two clocks.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_int_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  logic [15:0] lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_int_n),
    .q     (lfsr)
  );

  point_state_t       state_q,        state_d;
  logic [TRY_W-1:0]   try_cnt_q,      try_cnt_d;
  logic [DELAY_W-1:0] delay_cnt_q,    delay_cnt_d;
  logic [POS_W-1:0]   point_x_q,      point_x_d;
  logic [POS_W-1:0]   point_y_q,      point_y_d;
  logic               point_active_q, point_active_d;
  logic               entry_q,        entry_d;
  logic [SCORE_W-1:0] score_q,        score_d;

  logic [POS_W-1:0]  cand_x, cand_y;
  logic [DIST_W-1:0] cand_dx, cand_dy, hit_dx, hit_dy;
  logic              cand_in_bounds, cand_near_player, cand_ok, hit;
  logic              collect_pulse_c;

  assign cand_x  = lfsr[9:0];
  assign cand_y  = lfsr[15:6];
  assign cand_dx = abs_diff(cand_x, player_x);
  assign cand_dy = abs_diff(cand_y, player_y);
  assign hit_dx  = abs_diff(point_x_q, player_x);
  assign hit_dy  = abs_diff(point_y_q, player_y);

  assign cand_in_bounds   = (cand_x >= MIN_XY) && (cand_x <= MAX_X) &&
                            (cand_y >= MIN_XY) && (cand_y <= MAX_Y);
  assign cand_near_player = ({1'b0, cand_dx} < SPAWN_DIST) && ({1'b0, cand_dy} < SPAWN_DIST);
  assign cand_ok          = cand_in_bounds && !cand_near_player;
  assign hit              = (hit_dx < HIT_DIST) && (hit_dy < HIT_DIST);

  // Next-state logic; everything holds while the game is paused.
  always_comb begin
    state_d        = state_q;
    try_cnt_d      = try_cnt_q;
    delay_cnt_d    = delay_cnt_q;
    point_x_d      = point_x_q;
    point_y_d      = point_y_q;
    point_active_d = point_active_q;
    entry_d        = entry_q;
    score_d        = score_q;
    if (game_en) begin
      case (state_q)
        SPAWN: begin
          if (cand_ok || (try_cnt_q == LAST_TRY)) begin
            point_x_d      = cand_ok ? cand_x : POINT_FALLBACK_X;
            point_y_d      = cand_ok ? cand_y : POINT_FALLBACK_Y;
            try_cnt_d      = '0;
            point_active_d = 1'b1;
            entry_d        = 1'b1;
            state_d        = ACTIVE;
          end else begin
            try_cnt_d = try_cnt_q + TRY_W'(1);
          end
        end
        ACTIVE: begin
          // A tick landing on the entry cycle is ignored.
          entry_d = 1'b0;
          if (frame_tick && !entry_q && hit) state_d = COLLECTED;
        end
        COLLECTED: begin
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          point_active_d = 1'b0;
          delay_cnt_d    = '0;
          state_d        = COOLDOWN;
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (delay_cnt_q == LAST_DELAY) begin
              delay_cnt_d = '0;
              state_d     = SPAWN;
            end else begin
              delay_cnt_d = delay_cnt_q + DELAY_W'(1);
            end
          end
        end
        default: state_d = SPAWN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q        <= SPAWN;
      try_cnt_q      <= '0;
      delay_cnt_q    <= '0;
      point_x_q      <= RESET_X;
      point_y_q      <= RESET_Y;
      point_active_q <= 1'b0;
      entry_q        <= 1'b0;
      score_q        <= '0;
    end else begin
      state_q        <= state_d;
      try_cnt_q      <= try_cnt_d;
      delay_cnt_q    <= delay_cnt_d;
      point_x_q      <= point_x_d;
      point_y_q      <= point_y_d;
      point_active_q <= point_active_d;
      entry_q        <= entry_d;
      score_q        <= score_d;
    end
  end

  assign collect_pulse_c = (state_q == COLLECTED) && game_en;

  assign point_x       = point_x_q;
  assign point_y       = point_y_q;
  assign point_active  = point_active_q;
  assign collect_pulse = collect_pulse_c;
  assign score         = score_q;

endmodule

// File: tb/tb_point_spawn_ctrl.sv
// Directed bench: default instance, an always-fallback instance and a 2-bit score instance.
module tb_point_spawn_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       game_en;
  logic [9:0] player_x, player_y;

  logic [9:0]  px, py, fb_x, fb_y, sat_x, sat_y;
  logic        act, fb_act, sat_act;
  logic        pulse, fb_pulse, sat_pulse;
  logic [15:0] score, fb_score;
  logic [1:0]  sat_score;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  point_spawn_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_en(game_en),
    .player_x(player_x), .player_y(player_y), .point_x(px), .point_y(py),
    .point_active(act), .collect_pulse(pulse), .score(score)
  );

  point_spawn_ctrl #(.SPAWN_MARGIN(1023)) u_fb (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_en(game_en),
    .player_x(player_x), .player_y(player_y), .point_x(fb_x), .point_y(fb_y),
    .point_active(fb_act), .collect_pulse(fb_pulse), .score(fb_score)
  );

  point_spawn_ctrl #(.SCORE_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_en(game_en),
    .player_x(player_x), .player_y(player_y), .point_x(sat_x), .point_y(sat_y),
    .point_active(sat_act), .collect_pulse(sat_pulse), .score(sat_score)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  // Bounded wait for the respawn, then check legality against the current player.
  task automatic wait_spawn(input string tag);
    int n = 0;
    logic [9:0] ax, ay;
    logic ok, far;
    while (!act && n < 10) begin
      step();
      n++;
    end
    check({tag, "_active"}, 32'(act), 32'd1);
    ax  = (px >= player_x) ? px - player_x : player_x - px;
    ay  = (py >= player_y) ? py - player_y : player_y - py;
    ok  = (px >= 10'd8) && (px <= 10'd1015) && (py >= 10'd8) && (py <= 10'd759);
    far = !((ax < 10'd40) && (ay < 10'd40));
    check({tag, "_bounds"}, 32'(ok), 32'd1);
    check({tag, "_margin"}, 32'(far), 32'd1);
  endtask

  task automatic do_collect(input string tag, input int exp_score, input int exp_sat,
                            input bit respawn);
    player_x = px;
    player_y = py;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check({tag, "_pulse"}, 32'(pulse), 32'd1);
    step();
    check({tag, "_pulse_end"}, 32'(pulse), 32'd0);
    check({tag, "_score"}, 32'(score), 32'(exp_score));
    check({tag, "_sat_score"}, 32'(sat_score), 32'(exp_sat));
    check({tag, "_inactive"}, 32'(act), 32'd0);
    if (respawn) begin
      for (int i = 0; i < 60; i++) pulse_tick();
      wait_spawn({tag, "_respawn"});
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    game_en    = 1'b1;
    player_x   = 10'd512;
    player_y   = 10'd384;
    for (int i = 0; i < 5; i++) step();
    check("rst_x", 32'(px), 32'd512);
    check("rst_y", 32'(py), 32'd384);
    check("rst_active", 32'(act), 32'd0);
    check("rst_pulse", 32'(pulse), 32'd0);
    check("rst_score", 32'(score), 32'd0);

    // Two clocks of reset synchroniser, then the seed candidate (225,691) is accepted.
    rst_n = 1'b1;
    step();
    step();
    check("sync_active", 32'(act), 32'd0);
    step();
    check("spawn_active", 32'(act), 32'd1);
    check("spawn_x", 32'(px), 32'd225);
    check("spawn_y", 32'(py), 32'd691);
    check("fb_not_yet", 32'(fb_act), 32'd0);

    // Tick on the entry cycle with the player on the point must not collect.
    player_x   = 10'd225;
    player_y   = 10'd691;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("entry_no_pulse", 32'(pulse), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("fb_try7_inactive", 32'(fb_act), 32'd0);
    step();
    check("fb_active", 32'(fb_act), 32'd1);
    check("fb_x", 32'(fb_x), 32'd512);
    check("fb_y", 32'(fb_y), 32'd192);

    // Paused: ticks with the player on the point do nothing.
    game_en    = 1'b0;
    frame_tick = 1'b1;
    step();
    step();
    frame_tick = 1'b0;
    check("freeze_pulse", 32'(pulse), 32'd0);
    check("freeze_score", 32'(score), 32'd0);
    check("freeze_active", 32'(act), 32'd1);

    game_en    = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("c1_pulse", 32'(pulse), 32'd1);
    check("c1_score_pre", 32'(score), 32'd0);
    game_en = 1'b0;
    #1;
    check("c1_pulse_gated", 32'(pulse), 32'd0);
    step();
    check("c1_pulse_held", 32'(pulse), 32'd0);
    check("c1_score_held", 32'(score), 32'd0);
    game_en = 1'b1;
    #1;
    check("c1_pulse_resume", 32'(pulse), 32'd1);
    step();
    check("c1_pulse_end", 32'(pulse), 32'd0);
    check("c1_score", 32'(score), 32'd1);
    check("c1_sat_score", 32'(sat_score), 32'd1);
    check("c1_inactive", 32'(act), 32'd0);

    for (int i = 0; i < 59; i++) pulse_tick();
    check("cool59_inactive", 32'(act), 32'd0);
    pulse_tick();
    wait_spawn("c1_respawn");

    do_collect("c2", 2, 2, 1'b1);
    do_collect("c3", 3, 3, 1'b1);
    do_collect("c4", 4, 3, 1'b0);

    // Mid-cooldown reset between clock edges takes effect without a clock.
    for (int i = 0; i < 5; i++) pulse_tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_score", 32'(score), 32'd0);
    check("arst_sat_score", 32'(sat_score), 32'd0);
    check("arst_active", 32'(act), 32'd0);
    check("arst_x", 32'(px), 32'd512);
    check("arst_y", 32'(py), 32'd384);
    check("arst_pulse", 32'(pulse), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
